jt10_adpcma_enc: RTL and testbench
==================================

Name: jt10_adpcmA_enc

Overview:
- ADPCM-A (YM2610 "jedi") encoder. The inverse of the ADPCM-A decoder path.
- Converts a stream of signed 16-bit PCM samples into 4-bit codes and packs two codes per byte, high nibble first, matching the decoder's nibble order.
- Used to build ADPCM-A ROM images and test vectors for the drvA chain in simulation and on FPGA.
- Keeps a bit-exact copy of the decoder state (12-bit accumulator, step index), so the output decodes without drift.

Parameters:
- (none; all widths fixed by the ADPCM-A format)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only when cen=1
- clr  in  1  synchronous restart: acc=0, step index=0, nibble phase=high, pending byte dropped
- pcm_in  in  16  signed sample; encoder uses pcm_in[15:4] (12-bit target)
- pcm_valid  in  1  sample offered
- pcm_last  in  1  qualifies the final sample of a block; forces flush of an odd nibble
- pcm_ready  out  1  encoder accepts pcm_in this cen
- byte_out  out  8  packed codes, [7:4] first nibble, [3:0] second nibble
- byte_valid  out  1  byte_out holds a byte
- byte_ready  in  1  consumer takes the byte
- busy  out  1  FSM not IDLE
- acc_out  out  12  signed reconstructed sample (decoder mirror)
- step_idx  out  6  current step index, 0..48

Behaviour:
- Reset values: pcm_ready=1, byte_valid=0, byte_out=0, busy=0, acc_out=0, step_idx=0. Internally, nibble phase=high.
- Transfers happen on a cen cycle:
  - Input transfer when pcm_valid & pcm_ready.
  - Output transfer when byte_valid & byte_ready.
  - byte_out stays stable while byte_valid=1 and byte_ready=0.
- FSM, advancing one state per cen: IDLE -> DIFF -> SAR2 -> SAR1 -> SAR0 -> UPD -> IDLE. Latency from input transfer to acc_out/step_idx update is 5 cens. Throughput is one sample per 6 cens.
- DIFF:
  - diff = target - acc, computed at 13 bits.
  - sign = diff<0.
  - mag = |diff|.
  - step = STEP_TABLE[step_idx].
- SAR2..SAR0: m is built MSB first. Each bit is kept if ((m_trial*step)>>2) <= mag. Result: the largest m in 0..7 meeting that test.
- UPD:
  - code = {sign, m[2:0]}.
  - delta = ((2m+1)*step)>>3, negated if sign=1.
  - acc = (acc+delta) modulo 2^12, i.e. wraps exactly as the decoder does.
  - step_idx = clamp(step_idx + IDX_ADJ[m], 0, 48).
- Packing:
  - On phase=high, the code goes to byte_out[7:4] and phase toggles.
  - On phase=low, the code goes to byte_out[3:0], byte_valid=1, and phase returns to high.
  - If pcm_last was set on the sample and phase=high after its code is placed: pad [3:0]=0, assert byte_valid, and reset phase. Padding does not change acc or step_idx.
- pcm_ready = (state==IDLE) & !(byte_valid & !byte_ready). No sample is accepted while a completed byte is unconsumed.
- clr has priority over everything in the same cen. A sample in flight is abandoned and the FSM returns to IDLE.
- cen=0 freezes all state. Handshake signals are only sampled with cen=1.
- Reset asserted mid-operation returns all outputs to their reset values immediately.

Optional Feature:
- Macro: JT10_ADPCMA_ENC_NOWRAP_EN.
- When defined:
  - A FIX state is inserted between SAR0 and UPD. Throughput becomes 7 cens per sample.
  - In FIX, if acc+delta would leave the range -2048..2047 and m>0, m is decremented once.
  - The encoder therefore avoids codes that make the decoder wrap.
- When undefined: there is no FIX state, and wrap is mirrored blindly.

Decomposition:
- Package jt10_adpcmA_pkg:
  - STEP_TABLE[49]: 16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552.
  - IDX_ADJ[8]: -1,-1,-1,-1,2,5,7,9.
  - FSM state enum.
- Sub-module jt10_adpcmA_enc_core holds the decoder-mirror arithmetic: delta, accumulator wrap, index clamp. The same core is reusable as a golden model for the decoder check.

Test Plan:
- clr, then pcm_in=0x0000 -> code 0x0, acc_out=0x002, step_idx=0.
- Continue with pcm_in=0x7FF0 (target 2047) -> m=7, code 0x7, acc=32, step_idx=9, byte_out=0x07 with byte_valid=1.
- clr, then pcm_in=0xFFF0 (target -1) -> code 0x8, acc_out=0xFFE, step_idx=0.
- Odd block: clr, one sample 0x7FF0 with pcm_last=1 -> byte_out=0x70 and phase reset. A next sample 0x0000 lands in [7:4].
- Backpressure: hold byte_ready=0 after a completed byte -> pcm_ready=0 and byte_out stable. Release -> transfer, then pcm_ready=1 next cen.
- Feed a 1 kHz full-scale sine of 512 samples through encoder and decoder model -> decoder output equals acc_out every sample. With JT10_ADPCMA_ENC_NOWRAP_EN defined, acc never crosses from 2047 to -2048.

Source files
------------

// File: rtl/jt10_adpcma_enc_pkg.sv
// ADPCM-A (YM2610) encoder shared definitions.
// Holds the step-size table, the step-index adjustment table indexed by the
// 3-bit magnitude code, and the encoder FSM state encoding.
// Optional build macro used by the encoder: JT10_ADPCMA_ENC_NOWRAP_EN.
package jt10_adpcma_enc_pkg;

    localparam logic [5:0] IDX_MAX = 6'd48;

    localparam logic [10:0] STEP_TABLE [0:48] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [4:0] IDX_ADJ [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd5, 5'sd7, 5'sd9
    };

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIFF = 3'd1,
        ST_SAR2 = 3'd2,
        ST_SAR1 = 3'd3,
        ST_SAR0 = 3'd4,
        ST_FIX  = 3'd5,
        ST_UPD  = 3'd6
    } enc_state_e;

endpackage

// File: rtl/jt10_adpcma_enc_core.sv
// Decoder-mirror arithmetic for ADPCM-A, purely combinational.
// Given the current accumulator, step index and a code {sign, m}, produces
// the step size, the next accumulator (12-bit wrap, exactly as the decoder),
// the next clamped step index and a flag telling whether the decoder would
// wrap. Usable on its own as a golden decoder step.
// Ports:
//   acc     in  12  signed accumulator
//   idx     in   6  step index 0..48
//   sign    in   1  code sign bit
//   m       in   3  code magnitude
//   step    out 11  STEP_TABLE[idx]
//   acc_nxt out 12  acc + delta, modulo 2^12
//   idx_nxt out  6  clamp(idx + IDX_ADJ[m], 0, 48)
//   wraps   out  1  acc + delta falls outside -2048..2047
module jt10_adpcma_enc_core
    import jt10_adpcma_enc_pkg::*;
(
    input  logic [11:0] acc,
    input  logic [5:0]  idx,
    input  logic        sign,
    input  logic [2:0]  m,
    output logic [10:0] step,
    output logic [11:0] acc_nxt,
    output logic [5:0]  idx_nxt,
    output logic        wraps
);

    logic [14:0] dprod;
    logic [13:0] delta;
    logic [13:0] sum;
    logic [4:0]  adj;
    logic [7:0]  idx_sum;

    always_comb begin
        step    = STEP_TABLE[idx];
        // (2m+1)*step >> 3, at most 15*1552 before the shift
        dprod   = {11'd0, m, 1'b1} * {4'd0, step};
        delta   = sign ? (14'd0 - {2'b00, dprod[14:3]}) : {2'b00, dprod[14:3]};
        // 14-bit sum is wide enough to see the overflow before truncation
        sum     = {{2{acc[11]}}, acc} + delta;
        acc_nxt = sum[11:0];
        wraps   = (sum[13:11] != 3'b000) && (sum[13:11] != 3'b111);
        adj     = IDX_ADJ[m];
        idx_sum = {2'b00, idx} + {{3{adj[4]}}, adj};
        if (idx_sum[7]) begin
            idx_nxt = 6'd0;
        end else if (idx_sum > {2'b00, IDX_MAX}) begin
            idx_nxt = IDX_MAX;
        end else begin
            idx_nxt = idx_sum[5:0];
        end
    end

endmodule

// File: rtl/jt10_adpcma_enc.sv
// ADPCM-A (YM2610) encoder: signed 16-bit PCM in, packed 4-bit codes out,
// two codes per byte with the first code in [7:4]. Tracks the decoder state
// bit-exactly so the stream decodes without drift.
// Optional macro JT10_ADPCMA_ENC_NOWRAP_EN: adds a FIX state that backs the
// magnitude off by one when the decoder would otherwise wrap.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   cen                clock enable, all state frozen when low
//   clr                synchronous restart (priority over everything)
//   pcm_in/valid/last  sample input handshake, pcm_in[15:4] used
//   pcm_ready          sample accepted on this cen
//   byte_out/valid     packed code byte, held until byte_ready
//   byte_ready         consumer takes the byte
//   busy               FSM not idle
//   acc_out, step_idx  decoder-mirror accumulator and step index
//
// state   | meaning
// IDLE    | waiting for a sample (and a free output byte)
// DIFF    | diff = target - acc, latch sign and magnitude
// SAR2..0 | successive approximation of m, MSB first
// FIX     | (NOWRAP build only) drop m by one if the decoder would wrap
// UPD     | update acc/step index, pack the code into the output byte
module jt10_adpcma_enc
    import jt10_adpcma_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        clr,
    input  logic [15:0] pcm_in,
    input  logic        pcm_valid,
    input  logic        pcm_last,
    output logic        pcm_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic [11:0] acc_out,
    output logic [5:0]  step_idx
);

`ifdef JT10_ADPCMA_ENC_NOWRAP_EN
    localparam enc_state_e ST_AFTER_SAR = ST_FIX;
`else
    localparam enc_state_e ST_AFTER_SAR = ST_UPD;
`endif

    enc_state_e  state_q, state_d;
    logic [11:0] target_q, target_d;
    logic        last_q, last_d;
    logic        sign_q, sign_d;
    logic [11:0] mag_q, mag_d;
    logic [2:0]  m_q, m_d;
    logic [11:0] acc_q, acc_d;
    logic [5:0]  idx_q, idx_d;
    logic        phase_hi_q, phase_hi_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_valid_q, byte_valid_d;

    logic [10:0] step;
    logic [11:0] acc_nxt;
    logic [5:0]  idx_nxt;
    logic        wrap_w;
    logic [12:0] diff;
    logic [12:0] diff_neg;
    logic [2:0]  sar_bit;
    logic [2:0]  trial;
    logic [13:0] sar_prod;
    logic [3:0]  code;
    logic        pcm_ready_w;
    logic        unused_pcm_lsb;

    assign unused_pcm_lsb = ^pcm_in[3:0];

`ifndef JT10_ADPCMA_ENC_NOWRAP_EN
    logic unused_wrap;
    assign unused_wrap = wrap_w;
`endif

    jt10_adpcma_enc_core u_core (
        .acc     (acc_q),
        .idx     (idx_q),
        .sign    (sign_q),
        .m       (m_q),
        .step    (step),
        .acc_nxt (acc_nxt),
        .idx_nxt (idx_nxt),
        .wraps   (wrap_w)
    );

    // A completed byte that is not being taken this cen blocks new samples.
    assign pcm_ready_w = (state_q == ST_IDLE) && !(byte_valid_q && !byte_ready);

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        last_d       = last_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        m_d          = m_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        phase_hi_d   = phase_hi_q;
        byte_d       = byte_q;
        byte_valid_d = byte_valid_q;

        diff     = {target_q[11], target_q} - {acc_q[11], acc_q};
        diff_neg = 13'd0 - diff;
        code     = {sign_q, m_q};

        case (state_q)
            ST_SAR2: sar_bit = 3'b100;
            ST_SAR1: sar_bit = 3'b010;
            ST_SAR0: sar_bit = 3'b001;
            default: sar_bit = 3'b000;
        endcase
        trial    = m_q | sar_bit;
        sar_prod = {11'd0, trial} * {3'd0, step};

        if (cen) begin
            if (clr) begin
                state_d      = ST_IDLE;
                acc_d        = 12'd0;
                idx_d        = 6'd0;
                m_d          = 3'd0;
                phase_hi_d   = 1'b1;
                byte_d       = 8'd0;
                byte_valid_d = 1'b0;
            end else begin
                if (byte_valid_q && byte_ready) begin
                    byte_valid_d = 1'b0;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (pcm_valid && pcm_ready_w) begin
                            target_d = pcm_in[15:4];
                            last_d   = pcm_last;
                            m_d      = 3'd0;
                            state_d  = ST_DIFF;
                        end
                    end
                    ST_DIFF: begin
                        sign_d  = diff[12];
                        // |diff| <= 4095, so 12 bits always hold it
                        mag_d   = diff[12] ? diff_neg[11:0] : diff[11:0];
                        state_d = ST_SAR2;
                    end
                    ST_SAR2, ST_SAR1, ST_SAR0: begin
                        // (m*step)>>2 is monotonic in m, so MSB-first
                        // approximation yields the largest passing m.
                        if (sar_prod[13:2] <= mag_q) begin
                            m_d = trial;
                        end
                        case (state_q)
                            ST_SAR2: state_d = ST_SAR1;
                            ST_SAR1: state_d = ST_SAR0;
                            default: state_d = ST_AFTER_SAR;
                        endcase
                    end
`ifdef JT10_ADPCMA_ENC_NOWRAP_EN
                    ST_FIX: begin
                        if (wrap_w && (m_q != 3'd0)) begin
                            m_d = m_q - 3'd1;
                        end
                        state_d = ST_UPD;
                    end
`endif
                    ST_UPD: begin
                        acc_d = acc_nxt;
                        idx_d = idx_nxt;
                        if (phase_hi_q) begin
                            byte_d = {code, 4'h0};
                            if (last_q) begin
                                // odd block end: low nibble padded with zero
                                byte_valid_d = 1'b1;
                            end else begin
                                phase_hi_d = 1'b0;
                            end
                        end else begin
                            byte_d       = {byte_q[7:4], code};
                            byte_valid_d = 1'b1;
                            phase_hi_d   = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= 12'd0;
            last_q       <= 1'b0;
            sign_q       <= 1'b0;
            mag_q        <= 12'd0;
            m_q          <= 3'd0;
            acc_q        <= 12'd0;
            idx_q        <= 6'd0;
            phase_hi_q   <= 1'b1;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            last_q       <= last_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            m_q          <= m_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            phase_hi_q   <= phase_hi_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign pcm_ready  = pcm_ready_w;
    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign acc_out    = acc_q;
    assign step_idx   = idx_q;

endmodule

// File: tb/tb_jt10_adpcma_enc.sv
// Self-checking bench for jt10_adpcma_enc: directed cases plus random and
// sine streams, expected results from a plain-integer ADPCM-A model queued
// at sample acceptance and popped by an independent monitor.
module tb_jt10_adpcma_enc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] pcm_in = 16'd0;
    logic        pcm_valid = 1'b0;
    logic        pcm_last = 1'b0;
    logic        pcm_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        busy;
    logic [11:0] acc_out;
    logic [5:0]  step_idx;

    jt10_adpcma_enc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .clr        (clr),
        .pcm_in     (pcm_in),
        .pcm_valid  (pcm_valid),
        .pcm_last   (pcm_last),
        .pcm_ready  (pcm_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .acc_out    (acc_out),
        .step_idx   (step_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    bit cen_rand = 1'b0;
    int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) begin
        #1;
        cen = cen_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        case (rdy_mode)
            0:       byte_ready = 1'b0;
            1:       byte_ready = 1'b1;
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    int step_tab [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,
                          88,97,107,118,130,143,157,173,190,209,230,253,279,307,
                          337,371,408,449,494,544,598,658,724,796,876,963,1060,
                          1166,1282,1411,1552};
    int adj_tab [8] = '{-1,-1,-1,-1,2,5,7,9};
    int  acc_m = 0;
    int  idx_m = 0;
    bit  hi_m = 1'b1;
    int  hi_code = 0;

    logic [11:0] exp_acc_q [$];
    logic [5:0]  exp_idx_q [$];
    logic [7:0]  exp_byte_q [$];

    task automatic model_reset();
        acc_m = 0;
        idx_m = 0;
        hi_m = 1'b1;
        hi_code = 0;
        exp_acc_q.delete();
        exp_idx_q.delete();
        exp_byte_q.delete();
    endtask

    task automatic model_accept(input logic [15:0] pcm, input logic last);
        int tgt, diff, mag, step, m, delta, code;
        bit s;
        logic [7:0] b;
        tgt  = $signed(pcm[15:4]);
        diff = tgt - acc_m;
        s    = diff < 0;
        mag  = s ? -diff : diff;
        step = step_tab[idx_m];
        m = 0;
        for (int k = 0; k < 8; k++)
            if ((k * step) / 4 <= mag) m = k;
        delta = ((2 * m + 1) * step) / 8;
        if (s) delta = -delta;
`ifdef JT10_ADPCMA_ENC_NOWRAP_EN
        if ((acc_m + delta > 2047 || acc_m + delta < -2048) && m > 0) begin
            m = m - 1;
            delta = ((2 * m + 1) * step) / 8;
            if (s) delta = -delta;
        end
`endif
        acc_m = acc_m + delta;
        if (acc_m > 2047) acc_m -= 4096;
        else if (acc_m < -2048) acc_m += 4096;
        idx_m = idx_m + adj_tab[m];
        if (idx_m < 0) idx_m = 0;
        if (idx_m > 48) idx_m = 48;
        code = (s ? 8 : 0) + m;
        exp_acc_q.push_back(acc_m[11:0]);
        exp_idx_q.push_back(idx_m[5:0]);
        if (hi_m) begin
            if (last) begin
                b = {code[3:0], 4'h0};
                exp_byte_q.push_back(b);
            end else begin
                hi_code = code;
                hi_m = 1'b0;
            end
        end else begin
            b = {hi_code[3:0], code[3:0]};
            exp_byte_q.push_back(b);
            hi_m = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    bit         prev_busy = 1'b0;
    bit         prev_clr = 1'b0;
    bit         prev_hold = 1'b0;
    logic [7:0] held_byte = 8'd0;

    initial begin
        logic [11:0] ea;
        logic [5:0]  ei;
        logic [7:0]  eb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                prev_clr  = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (prev_busy && !busy && !prev_clr) begin
                    if (exp_acc_q.size() == 0) begin
                        fail_now("sample_unexpected");
                    end else begin
                        ea = exp_acc_q.pop_front();
                        ei = exp_idx_q.pop_front();
                        check("acc_out", 32'(acc_out), 32'(ea));
                        check("step_idx", 32'(step_idx), 32'(ei));
                    end
                end
                if (prev_hold && byte_valid)
                    check("byte_hold", 32'(byte_out), 32'(held_byte));
                if (cen && !clr && byte_valid && byte_ready) begin
                    if (exp_byte_q.size() == 0) begin
                        fail_now("byte_unexpected");
                    end else begin
                        eb = exp_byte_q.pop_front();
                        check("byte_out", 32'(byte_out), 32'(eb));
                    end
                end
                prev_hold = byte_valid && !(cen && (byte_ready || clr));
                held_byte = byte_out;
                prev_busy = busy;
                prev_clr  = cen && clr;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] pcm, input logic last, input bit use_model);
        int n = 0;
        bit done = 1'b0;
        @(posedge clk);
        #1;
        pcm_in = pcm;
        pcm_last = last;
        pcm_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (cen && pcm_ready) begin
                done = 1'b1;
                if (use_model) model_accept(pcm, last);
            end else if (++n > 300) begin
                fail_now("accept_timeout");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        pcm_valid = 1'b0;
        pcm_last = 1'b0;
    endtask

    task automatic do_clr();
        int n = 0;
        bit done = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (cen) begin
                done = 1'b1;
                model_reset();
            end else if (++n > 100) begin
                fail_now("clr_timeout");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now("idle_timeout");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        #12;
        check("rst_pcm_ready", 32'(pcm_ready), 1);
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_byte_out", 32'(byte_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_acc", 32'(acc_out), 0);
        check("rst_idx", 32'(step_idx), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first samples from a cleared state
        cen_rand = 1'b0;
        rdy_mode = 0;
        do_clr();
        send(16'h0000, 1'b0, 1'b1);
        wait_idle();
        check("zero_acc", 32'(acc_out), 32'h002);
        check("zero_idx", 32'(step_idx), 0);
        send(16'h7FF0, 1'b0, 1'b1);
        wait_idle();
        check("max_acc", 32'(acc_out), 32);
        check("max_idx", 32'(step_idx), 9);
        check("max_bvalid", 32'(byte_valid), 1);
        check("max_byte", 32'(byte_out), 32'h07);
        rdy_mode = 1;
        repeat (3) @(negedge clk);

        // negative one from zero
        do_clr();
        send(16'hFFF0, 1'b0, 1'b1);
        wait_idle();
        check("neg_acc", 32'(acc_out), 32'hFFE);
        check("neg_idx", 32'(step_idx), 0);

        // odd block with last
        rdy_mode = 0;
        do_clr();
        send(16'h7FF0, 1'b1, 1'b1);
        wait_idle();
        check("odd_bvalid", 32'(byte_valid), 1);
        check("odd_byte", 32'(byte_out), 32'h70);
        check("odd_acc", 32'(acc_out), 30);
        rdy_mode = 1;
        send(16'h0000, 1'b0, 1'b1);
        send(16'h0000, 1'b0, 1'b1);
        wait_idle();

        // backpressure
        rdy_mode = 0;
        send(16'h1230, 1'b0, 1'b1);
        send(16'h2340, 1'b0, 1'b1);
        wait_idle();
        check("bp_bvalid", 32'(byte_valid), 1);
        check("bp_ready_low", 32'(pcm_ready), 0);
        pcm_in = 16'h5550;
        pcm_valid = 1'b1;
        repeat (6) @(negedge clk);
        check("bp_not_accepted", 32'(busy), 0);
        check("bp_ready_still_low", 32'(pcm_ready), 0);
        pcm_valid = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_back", 32'(pcm_ready), 1);
        check("bp_bvalid_clear", 32'(byte_valid), 0);

        // clr abandons an in-flight sample
        send(16'h4000, 1'b0, 1'b0);
        do_clr();
        @(negedge clk);
        check("abandon_busy", 32'(busy), 0);
        check("abandon_acc", 32'(acc_out), 0);
        check("abandon_idx", 32'(step_idx), 0);

        // asynchronous reset mid-operation
        send(16'h7FF0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(pcm_ready), 1);
        check("mid_rst_acc", 32'(acc_out), 0);
        check("mid_rst_bvalid", 32'(byte_valid), 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random stream with random cen and consumer stalls
        cen_rand = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 300; i++)
            send(16'($urandom()), ($urandom_range(0, 7) == 0), 1'b1);
        wait_idle();

        // full-scale 1 kHz sine, even block
        cen_rand = 1'b0;
        do_clr();
        for (int n = 0; n < 512; n++) begin
            s = $rtoi(32767.0 * $sin(6.283185307 * 1000.0 * real'(n) / 18500.0));
            send(s[15:0], 1'b0, 1'b1);
        end
        wait_idle();

        rdy_mode = 1;
        repeat (10) @(negedge clk);
        check("byte_q_drained", 32'(exp_byte_q.size()), 0);
        check("samp_q_drained", 32'(exp_acc_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
